// File: rtl/teeter_pkg.sv
// Shared definitions for the teeter game step sequencer and its integrators.
package teeter_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_SERVE = 3'd1,
      ST_RUN   = 3'd2,
      ST_VEL   = 3'd3,
      ST_POS   = 3'd4,
      ST_CHK   = 3'd5,
      ST_OVER  = 3'd6
   } state_t;

   localparam int POS_MIN_DEF    = 0;
   localparam int POS_MAX_DEF    = 100;
   localparam int POSITION_SHIFT = 8;

   // The three cycles of a physics step, during which the tick keeps counting.
   function automatic logic is_step_phase(input state_t s);
      return (s == ST_VEL) || (s == ST_POS) || (s == ST_CHK);
   endfunction

endpackage

// File: rtl/teeter_step_ctrl_if.sv
// Control bundle between the step sequencer and the position/velocity integrators.
interface teeter_step_ctrl_if;
   logic               o_rst0;
   logic               o_rst1;
   logic               o_rst2;
   logic [9:0]         o_serve_value;
   logic               o_calc_vel;
   logic               o_calc_time;
   logic               o_vel_clr;
   logic               o_vel_reflect;
   logic signed [31:0] i_pos;

   modport master (
      output o_rst0, o_rst1, o_rst2, o_serve_value,
      output o_calc_vel, o_calc_time, o_vel_clr, o_vel_reflect,
      input  i_pos
   );

   modport slave (
      input  o_rst0, o_rst1, o_rst2, o_serve_value,
      input  o_calc_vel, o_calc_time, o_vel_clr, o_vel_reflect,
      output i_pos
   );
endinterface

// File: rtl/teeter_tick_gen.sv
// Physics-step tick counter: counts 0..TICK_DIV-1 while enabled, pulses wrap on the last count.
module teeter_tick_gen #(
   parameter int TICK_DIV = 100000,
   parameter int CNT_W    = 17
) (
   input  logic CLK,
   input  logic RST,
   input  logic enable,
   input  logic clear,
   output logic wrap
);

   localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

   logic [CNT_W-1:0] cnt_reg;
   logic [CNT_W-1:0] cnt_next;

   // Combinational so the FSM can leave RUN on the same cycle the count wraps.
   assign wrap = enable && (cnt_reg == LAST);

   always_comb begin
      cnt_next = cnt_reg;
      if (clear) begin
         cnt_next = '0;
      end else if (enable) begin
         cnt_next = (cnt_reg == LAST) ? '0 : cnt_reg + 1'b1;
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         cnt_reg <= '0;
      end else begin
         cnt_reg <= cnt_next;
      end
   end

endmodule

// File: rtl/teeter_step_ctrl.sv
// Teeter game sequencer: serve, periodic velocity/position step, wall check, game FSM.
module teeter_step_ctrl
   import teeter_pkg::*;
#(
   parameter int TICK_DIV = 100000,
   parameter int POS_MIN  = POS_MIN_DEF,
   parameter int POS_MAX  = POS_MAX_DEF,
   parameter int CNT_W    = 17
) (
   input  logic                    CLK,
   input  logic                    RST,
   input  logic                    i_start,
   input  logic                    i_abort,
   input  logic                    i_pause,
   input  logic                    i_bounce_mode,
   input  logic [9:0]              i_serve_pos,
   teeter_step_ctrl_if.master      integ,
   output logic                    o_hit_min,
   output logic                    o_hit_max,
   output logic [2:0]              o_state,
   output logic [15:0]             o_step_count
);

   localparam logic signed [31:0] POS_MIN_S = 32'(POS_MIN);
   localparam logic signed [31:0] POS_MAX_S = 32'(POS_MAX);

   state_t      state_reg, state_next;
   logic        rst0_reg, rst1_reg, rst2_reg, calc_vel_reg, calc_time_reg, reflect_reg;
   logic        rst1_next, rst2_next, reflect_next;
   logic [9:0]  serve_value_reg;
   logic        hit_min_reg, hit_max_reg;
   logic [15:0] step_count_reg;
   logic        below, above, tick_wrap, tick_en, tick_clr, start_ok;

   assign below    = integ.i_pos < POS_MIN_S;
   assign above    = integ.i_pos > POS_MAX_S;
   assign start_ok = ((state_reg == ST_IDLE) || (state_reg == ST_OVER)) && i_start && !i_abort;
   assign tick_clr = (state_reg == ST_SERVE) && !i_abort;
   assign tick_en  = !i_abort &&
                     (((state_reg == ST_RUN) && !i_pause) || is_step_phase(state_reg));

   teeter_tick_gen #(
      .TICK_DIV (TICK_DIV),
      .CNT_W    (CNT_W)
   ) u_tick (
      .CLK    (CLK),
      .RST    (RST),
      .enable (tick_en),
      .clear  (tick_clr),
      .wrap   (tick_wrap)
   );

   always_comb begin
      state_next   = state_reg;
      rst1_next    = 1'b0;
      rst2_next    = 1'b0;
      reflect_next = 1'b0;
      case (state_reg)
         ST_IDLE, ST_OVER: if (i_start) state_next = ST_SERVE;
         ST_SERVE:         state_next = ST_RUN;
         ST_RUN:           if (tick_wrap) state_next = ST_VEL;
         ST_VEL:           state_next = ST_POS;
         ST_POS:           state_next = ST_CHK;
         ST_CHK: begin
            state_next = ST_RUN;
            if (below || above) begin
               if (i_bounce_mode) begin
                  rst1_next    = below;
                  rst2_next    = above;
                  reflect_next = 1'b1;
               end else begin
                  state_next = ST_OVER;
               end
            end
         end
         default:          state_next = ST_IDLE;
      endcase
      if (i_abort) begin
         state_next   = ST_IDLE;
         rst1_next    = 1'b0;
         rst2_next    = 1'b0;
         reflect_next = 1'b0;
      end
   end

   // Strobes are flops decoded from the next state, so each is high exactly while its state is.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_reg       <= ST_IDLE;
         rst0_reg        <= 1'b0;
         rst1_reg        <= 1'b0;
         rst2_reg        <= 1'b0;
         calc_vel_reg    <= 1'b0;
         calc_time_reg   <= 1'b0;
         reflect_reg     <= 1'b0;
         serve_value_reg <= '0;
         hit_min_reg     <= 1'b0;
         hit_max_reg     <= 1'b0;
         step_count_reg  <= '0;
      end else begin
         state_reg     <= state_next;
         rst0_reg      <= (state_next == ST_SERVE);
         calc_vel_reg  <= (state_next == ST_VEL);
         calc_time_reg <= (state_next == ST_POS);
         rst1_reg      <= rst1_next;
         rst2_reg      <= rst2_next;
         reflect_reg   <= reflect_next;
         if (start_ok) serve_value_reg <= i_serve_pos;
         if ((state_reg == ST_SERVE) && !i_abort) begin
            hit_min_reg    <= 1'b0;
            hit_max_reg    <= 1'b0;
            step_count_reg <= '0;
         end else if ((state_reg == ST_CHK) && !i_abort) begin
            step_count_reg <= step_count_reg + 16'd1;
            if (below) hit_min_reg <= 1'b1;
            if (above) hit_max_reg <= 1'b1;
         end
      end
   end

   assign integ.o_rst0        = rst0_reg;
   assign integ.o_vel_clr     = rst0_reg;
   assign integ.o_rst1        = rst1_reg;
   assign integ.o_rst2        = rst2_reg;
   assign integ.o_vel_reflect = reflect_reg;
   assign integ.o_calc_vel    = calc_vel_reg;
   assign integ.o_calc_time   = calc_time_reg;
   assign integ.o_serve_value = serve_value_reg;
   assign o_hit_min           = hit_min_reg;
   assign o_hit_max           = hit_max_reg;
   assign o_state             = state_reg;
   assign o_step_count        = step_count_reg;

endmodule

// File: tb/tb_teeter_step_ctrl.sv
// Directed bench for teeter_step_ctrl with TICK_DIV=8, POS_MIN=0, POS_MAX=100.
module tb_teeter_step_ctrl;

   logic       CLK;
   logic       RST;
   logic       i_start, i_abort, i_pause, i_bounce_mode;
   logic [9:0] i_serve_pos;
   logic       o_hit_min, o_hit_max;
   logic [2:0] o_state;
   logic [15:0] o_step_count;

   int total, bad, cyc;
   int n_vel, n_time, n_r0, n_r1, n_r2;
   int t0, t1, prev, snap_vel, snap_time, snap_r0, snap_r1, snap_r2;

   teeter_step_ctrl_if ifc ();

   teeter_step_ctrl #(
      .TICK_DIV (8),
      .POS_MIN  (0),
      .POS_MAX  (100),
      .CNT_W    (4)
   ) dut (
      .CLK           (CLK),
      .RST           (RST),
      .i_start       (i_start),
      .i_abort       (i_abort),
      .i_pause       (i_pause),
      .i_bounce_mode (i_bounce_mode),
      .i_serve_pos   (i_serve_pos),
      .integ         (ifc),
      .o_hit_min     (o_hit_min),
      .o_hit_max     (o_hit_max),
      .o_state       (o_state),
      .o_step_count  (o_step_count)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   always @(negedge CLK) begin
      if (ifc.o_calc_vel)  n_vel++;
      if (ifc.o_calc_time) n_time++;
      if (ifc.o_rst0)      n_r0++;
      if (ifc.o_rst1)      n_r1++;
      if (ifc.o_rst2)      n_r2++;
   end

   task automatic chk(input string tag, input int got, input int want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s got=%0d want=%0d", tag, got, want);
      end else begin
         $display("ok   %s = %0d", tag, got);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
      cyc++;
   endtask

   task automatic wait_vel(output int t);
      int n;
      n = 0;
      do begin
         step();
         n++;
      end while (!ifc.o_calc_vel && n < 40);
      if (!ifc.o_calc_vel) chk("vel_timeout", 0, 1);
      t = cyc;
   endtask

   task automatic snap();
      snap_vel  = n_vel;
      snap_time = n_time;
      snap_r0   = n_r0;
      snap_r1   = n_r1;
      snap_r2   = n_r2;
   endtask

   task automatic chk_quiet(input string tag);
      chk(tag, (n_vel - snap_vel) + (n_time - snap_time) + (n_r0 - snap_r0) +
               (n_r1 - snap_r1) + (n_r2 - snap_r2), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1);
   end

   initial begin
      total = 0; bad = 0; cyc = 0;
      n_vel = 0; n_time = 0; n_r0 = 0; n_r1 = 0; n_r2 = 0;
      RST = 1'b1;
      i_start = 1'b0; i_abort = 1'b0; i_pause = 1'b0; i_bounce_mode = 1'b0;
      i_serve_pos = 10'd0;
      ifc.i_pos = 32'sd50;
      repeat (3) @(posedge CLK);
      #1;
      chk("rst_state", o_state, 0);
      chk("rst_count", o_step_count, 0);
      chk("rst_rst0", ifc.o_rst0, 0);
      chk("rst_serve_value", ifc.o_serve_value, 0);
      RST = 1'b0;
      step();
      chk("idle_state", o_state, 0);

      // Serve and first step
      i_serve_pos = 10'd50;
      i_start = 1'b1;
      step();
      i_start = 1'b0;
      chk("serve_state", o_state, 1);
      chk("serve_rst0", ifc.o_rst0, 1);
      chk("serve_vel_clr", ifc.o_vel_clr, 1);
      chk("serve_value", ifc.o_serve_value, 50);
      step();
      chk("run_state", o_state, 2);
      chk("run_rst0_low", ifc.o_rst0, 0);
      prev = cyc;
      wait_vel(t0);
      chk("first_vel_delay", t0 - prev, 8);
      step();
      chk("first_calc_time", ifc.o_calc_time, 1);
      chk("first_vel_low", ifc.o_calc_vel, 0);
      step();
      chk("first_chk_state", o_state, 5);
      step();
      chk("first_count", o_step_count, 1);

      // Steady run, 9 more steps
      prev = t0;
      for (int i = 0; i < 9; i++) begin
         wait_vel(t1);
         chk($sformatf("period_%0d", i), t1 - prev, 8);
         prev = t1;
      end
      repeat (3) step();
      chk("steady_count", o_step_count, 10);
      chk("steady_no_clamps", n_r1 + n_r2, 0);

      // Bounce at max wall
      i_bounce_mode = 1'b1;
      ifc.i_pos = 32'sd101;
      wait_vel(t1);
      step();
      step();
      step();
      chk("bounce_rst2", ifc.o_rst2, 1);
      chk("bounce_reflect", ifc.o_vel_reflect, 1);
      chk("bounce_rst1_low", ifc.o_rst1, 0);
      chk("bounce_hit_max", o_hit_max, 1);
      chk("bounce_state", o_state, 2);
      step();
      chk("bounce_rst2_one_cycle", ifc.o_rst2, 0);
      ifc.i_pos = 32'sd100;
      snap();
      wait_vel(t1);
      repeat (3) step();
      chk("edge_no_rst2", n_r2 - snap_r2, 0);
      chk("edge_hit_min", o_hit_min, 0);
      chk("edge_count", o_step_count, 12);

      // Game mode, min wall ends game
      i_bounce_mode = 1'b0;
      ifc.i_pos = -32'sd1;
      wait_vel(t1);
      repeat (3) step();
      chk("over_state", o_state, 6);
      chk("over_hit_min", o_hit_min, 1);
      chk("over_no_rst1", n_r1, 0);
      chk("over_count", o_step_count, 13);
      snap();
      repeat (12) step();
      chk_quiet("over_quiet");
      chk("over_hold_state", o_state, 6);

      // Re-serve from OVER
      ifc.i_pos = 32'sd50;
      i_serve_pos = 10'd7;
      i_start = 1'b1;
      step();
      i_start = 1'b0;
      chk("reserve_state", o_state, 1);
      chk("reserve_value", ifc.o_serve_value, 7);
      step();
      chk("reserve_hit_min", o_hit_min, 0);
      chk("reserve_hit_max", o_hit_max, 0);
      chk("reserve_count", o_step_count, 0);

      // Pause from S_VEL for 20 cycles
      wait_vel(t0);
      i_pause = 1'b1;
      step();
      chk("pause_calc_time", ifc.o_calc_time, 1);
      step();
      snap();
      repeat (18) step();
      i_pause = 1'b0;
      chk_quiet("pause_quiet");
      wait_vel(t1);
      chk("pause_next_step", t1 - t0, 25);

      // Abort in S_POS
      step();
      i_abort = 1'b1;
      step();
      i_abort = 1'b0;
      chk("abort_state", o_state, 0);
      chk("abort_calc_time", ifc.o_calc_time, 0);
      chk("abort_count_held", o_step_count, 1);
      snap();
      repeat (10) step();
      chk_quiet("abort_quiet");
      chk("abort_idle_hold", o_state, 0);

      // Reset mid-step
      i_start = 1'b1;
      step();
      i_start = 1'b0;
      step();
      wait_vel(t1);
      repeat (3) step();
      chk("prerst_count", o_step_count, 1);
      wait_vel(t1);
      step();
      RST = 1'b1;
      #1;
      chk("midrst_state", o_state, 0);
      chk("midrst_count", o_step_count, 0);
      chk("midrst_calc_time", ifc.o_calc_time, 0);
      step();
      RST = 1'b0;
      snap();
      repeat (12) step();
      chk_quiet("midrst_quiet");
      chk("midrst_idle_hold", o_state, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/teeter_step_ctrl.md
Name: teeter_step_ctrl

Overview:
- Sequencer for the ball position integrator and its companion velocity integrator in the teeter game.
- Generates the periodic physics step: velocity update strobe, then position update strobe, then a bounds check on the new position.
- Drives the integrator's serve/clamp controls: o_rst0 for serve, o_rst1 for clamp-to-min, o_rst2 for clamp-to-max.
- Runs a small game FSM: idle, serve, run, pause, over.

Parameters:
- TICK_DIV, 100000: clock cycles per physics step. Legal range is 4 or more.
- POS_MIN, 0: lower integer position bound, signed. Must equal the integrator's RST1_VALUE.
- POS_MAX, 100: upper integer position bound, signed. Must equal the integrator's RST2_VALUE. POS_MIN < POS_MAX is required.
- CNT_W, 17: width of the tick counter. Requires 2^CNT_W >= TICK_DIV.

Ports:
- CLK  in  1  system clock.
- RST  in  1  asynchronous, active-high reset.
- i_start  in  1  pulse; serve a new ball from IDLE or OVER.
- i_abort  in  1  level; force IDLE from any state.
- i_pause  in  1  level; freeze stepping while in RUN.
- i_bounce_mode  in  1  1 = clamp at a wall and reflect velocity; 0 = a wall hit ends the game.
- i_serve_pos  in  10  serve position, passed through as o_serve_value.
- i_pos  in  32  signed integer position from the integrator (already shifted down).
- o_rst0  out  1  one-cycle serve strobe to the integrator.
- o_rst1  out  1  one-cycle clamp-to-POS_MIN strobe.
- o_rst2  out  1  one-cycle clamp-to-POS_MAX strobe.
- o_serve_value  out  10  value presented with o_rst0. Registered from i_serve_pos on i_start.
- o_calc_vel  out  1  one-cycle velocity-update strobe.
- o_calc_time  out  1  one-cycle position-update strobe; drives the integrator's calc input.
- o_vel_clr  out  1  one-cycle velocity clear, coincident with o_rst0.
- o_vel_reflect  out  1  one-cycle velocity negate request.
- o_hit_min  out  1  sticky flag; cleared on serve.
- o_hit_max  out  1  sticky flag; cleared on serve.
- o_state  out  3  FSM state code.
- o_step_count  out  16  completed steps since the last serve.

Behaviour:
- Reset: all outputs registered and 0; FSM in IDLE; tick counter 0. Reset is legal mid-step; the step is abandoned with no strobes afterwards.
- State codes: IDLE=0, SERVE=1, RUN=2, S_VEL=3, S_POS=4, S_CHK=5, OVER=6.
- IDLE or OVER + i_start -> SERVE:
  - One cycle with o_rst0=1, o_vel_clr=1.
  - Clears the hit flags, o_step_count and the tick counter.
  - Next state is RUN.
- RUN, tick counter:
  - Increments each cycle while i_pause=0; holds while i_pause=1.
  - Also increments during S_VEL, S_POS and S_CHK, so the step period is exactly TICK_DIV cycles.
  - Wraps TICK_DIV-1 -> 0. On the wrap cycle the FSM moves to S_VEL.
- S_VEL: o_calc_vel=1 for one cycle -> S_POS.
- S_POS: o_calc_time=1 for one cycle -> S_CHK. The integrator updates at the end of this cycle.
- S_CHK: samples i_pos, which is now post-update. Comparisons are signed and strict; equal to a bound is in range.
  - i_pos < POS_MIN:
    - Sets o_hit_min.
    - If i_bounce_mode=1: o_rst1=1 and o_vel_reflect=1 for one cycle.
    - If i_bounce_mode=0: goes to OVER.
  - i_pos > POS_MAX: same as above using o_rst2 and o_hit_max.
  - o_step_count increments (wrapping 65535 -> 0) on every S_CHK, hit or not.
  - Next state is RUN, unless OVER was selected.
- i_pause asserted during S_VEL, S_POS or S_CHK: the step still completes; the freeze takes effect in RUN.
- i_abort: highest priority. Goes to IDLE next cycle from any state; no strobes that cycle; counters hold their values.
- i_start outside IDLE/OVER is ignored. i_start and i_abort together resolve to IDLE.
- Strobes are mutually exclusive except the coincident pairs o_rst0+o_vel_clr and o_rst1/2+o_vel_reflect.
- OVER holds all strobes at 0 and keeps flags and count visible.

Decomposition:
- Shared package teeter_pkg: FSM state codes, default POS_MIN/POS_MAX/POSITION_SHIFT constants shared with the integrator.
- One sub-module, teeter_tick_gen:
  - Inputs: enable, clear.
  - Output: wrap pulse.
  - Parameters: TICK_DIV and CNT_W.

Test Plan (TICK_DIV=8, POS_MIN=0, POS_MAX=100):
- Reset, then i_start with i_serve_pos=50 -> o_rst0 and o_vel_clr high exactly one cycle, o_serve_value=50; first o_calc_vel 8 cycles after RUN entry, o_calc_time the next cycle, o_step_count=1 after S_CHK.
- Steady run, i_pos held at 50, 10 steps -> strobe period exactly 8 cycles; o_step_count=10; no o_rst1 or o_rst2.
- Bounce mode, i_pos=101 at S_CHK -> o_rst2 and o_vel_reflect one cycle, o_hit_max=1, state returns to RUN; i_pos=100 -> no hit.
- Game mode, i_pos=-1 at S_CHK -> o_hit_min=1, state OVER, no o_rst1; later i_start -> SERVE, flags cleared.
- i_pause asserted on the S_VEL cycle for 20 cycles -> o_calc_time still fires next cycle; then no strobes for 20 cycles; next step occurs at the remaining count plus the pause length.
- i_abort during S_POS, and separately RST mid-step -> IDLE with no further strobes; RST clears o_step_count to 0, i_abort keeps it.
